dot_product_engine: RTL and testbench

DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

---
 rtl/dot_product_pkg.sv | 23 ++
 rtl/dp_lane_mac.sv | 42 ++++
 rtl/dot_product_engine.sv | 187 ++++++++++++++++++
 tb/tb_dot_product_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product engine: controller state encoding
// and the helpers that derive beat count and result width from the vector
// geometry.
package dot_product_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } dp_state_t;

  // Cycles needed to walk one vector when LANES elements are consumed per cycle.
  function automatic int dp_beats(input int vec_len, input int lanes);
    return vec_len / lanes;
  endfunction

  // Full-precision width of a VEC_LEN-term sum of DATA_WIDTH x DATA_WIDTH products.
  function automatic int dp_result_width(input int data_width, input int vec_len);
    return 2 * data_width + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/dp_lane_mac.sv
// Combinational LANES-wide multiply plus adder tree.
// Ports:
//   a_vec, b_vec : LANES operand elements each
//   is_signed    : 1 = two's-complement operands, 0 = unsigned
//   sum          : sum of the LANES products, extended to RESULT_WIDTH
module dp_lane_mac #(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 2,
  parameter int RESULT_WIDTH = 19
) (
  input  logic [LANES-1:0][DATA_WIDTH-1:0] a_vec,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] b_vec,
  input  logic                             is_signed,
  output logic [RESULT_WIDTH-1:0]          sum
);

  localparam int PW = 2 * DATA_WIDTH + 2;

  // Operands get one extra bit that carries either their sign or a zero, so a
  // single signed multiplier serves both modes and the product's top bit is
  // already the correct extension bit for RESULT_WIDTH.
  logic signed [DATA_WIDTH:0]   a_ext;
  logic signed [DATA_WIDTH:0]   b_ext;
  logic signed [PW-1:0]         prod;
  logic        [RESULT_WIDTH-1:0] term;

  always_comb begin
    sum   = '0;
    a_ext = '0;
    b_ext = '0;
    prod  = '0;
    term  = '0;
    for (int l = 0; l < LANES; l++) begin
      a_ext = {is_signed & a_vec[l][DATA_WIDTH-1], a_vec[l]};
      b_ext = {is_signed & b_vec[l][DATA_WIDTH-1], b_vec[l]};
      prod  = a_ext * b_ext;
      term  = RESULT_WIDTH'(prod);
      sum   = sum + term;
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product engine: computes pair_count dot products from a bank of
// operand vector pairs and stores each into its result slot.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, pair_count,
//   cfg_signed               : run request and its configuration
//   busy, done, cfg_err      : run status, completion pulse, illegal-start pulse
//   wr_en, wr_pair, wr_idx,
//   wr_a, wr_b, wr_err       : operand write port and rejected-write pulse
//   rd_en, rd_addr, rd_data,
//   rd_valid                 : registered result read port
//   results_written          : result slots stored in the current/last run
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a legal start; operand writes accepted
// ST_COMPUTE | accumulating LANES products per cycle for pair pair_idx
// ST_WRITE   | storing the accumulator into result slot pair_idx
// ST_DONE    | one-cycle done pulse, then back to idle
module dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LEN      = 8,
  parameter int LANES        = 2,
  parameter int NUM_PAIRS    = 4,
  parameter int RESULT_WIDTH = dp_result_width(DATA_WIDTH, VEC_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(NUM_PAIRS):0]   pair_count,
  input  logic                         cfg_signed,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_PAIRS)-1:0] wr_pair,
  input  logic [$clog2(VEC_LEN)-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0]        wr_a,
  input  logic [DATA_WIDTH-1:0]        wr_b,
  output logic                         wr_err,
  input  logic                         rd_en,
  input  logic [$clog2(NUM_PAIRS)-1:0] rd_addr,
  output logic [RESULT_WIDTH-1:0]      rd_data,
  output logic                         rd_valid,
  output logic [$clog2(NUM_PAIRS):0]   results_written
);

  localparam int BEATS  = dp_beats(VEC_LEN, LANES);
  localparam int PAIR_W = $clog2(NUM_PAIRS);
  localparam int CNT_W  = PAIR_W + 1;
  localparam int IDX_W  = $clog2(VEC_LEN);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  dp_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]   a_mem   [NUM_PAIRS][VEC_LEN];
  logic [DATA_WIDTH-1:0]   b_mem   [NUM_PAIRS][VEC_LEN];
  logic [RESULT_WIDTH-1:0] res_mem [NUM_PAIRS];

  logic [BEAT_W-1:0]       beat_left;
  logic [BEAT_W-1:0]       beat_num;
  logic [PAIR_W-1:0]       pair_idx;
  logic [CNT_W-1:0]        pair_cnt_q;
  logic                    signed_q;
  logic [RESULT_WIDTH-1:0] acc;
  logic [RESULT_WIDTH-1:0] lane_sum;
  logic [IDX_W-1:0]        elem_idx;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_a;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_b;
  logic pair_ok, start_ok, last_pair, wr_ok;

  assign pair_ok   = (pair_count != '0) && (pair_count <= CNT_W'(NUM_PAIRS));
  assign start_ok  = (state == ST_IDLE) && start && pair_ok;
  assign last_pair = ({1'b0, pair_idx} + CNT_W'(1)) == pair_cnt_q;
  // A write coinciding with an accepted start would race the first beat.
  assign wr_ok     = wr_en && !busy && !start_ok;

  // beat_left counts down, so the element window advances as it falls.
  assign beat_num = BEAT_LAST - beat_left;

  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    elem_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      elem_idx  = IDX_W'(int'(beat_num) * LANES + l);
      lane_a[l] = a_mem[pair_idx][elem_idx];
      lane_b[l] = b_mem[pair_idx][elem_idx];
    end
  end

  dp_lane_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LANES       (LANES),
    .RESULT_WIDTH(RESULT_WIDTH)
  ) u_lane_mac (
    .a_vec    (lane_a),
    .b_vec    (lane_b),
    .is_signed(signed_q),
    .sum      (lane_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (beat_left == '0) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        state_nxt = last_pair ? ST_DONE : ST_COMPUTE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_left       <= '0;
      pair_idx        <= '0;
      pair_cnt_q      <= '0;
      signed_q        <= 1'b0;
      acc             <= '0;
      results_written <= '0;
      cfg_err         <= 1'b0;
      wr_err          <= 1'b0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
    end else begin
      cfg_err  <= (state == ST_IDLE) && start && !pair_ok;
      wr_err   <= wr_en && !wr_ok;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= res_mem[rd_addr];
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            pair_cnt_q      <= pair_count;
            signed_q        <= cfg_signed;
            results_written <= '0;
            acc             <= '0;
            pair_idx        <= '0;
            beat_left       <= BEAT_LAST;
          end
        end
        ST_COMPUTE: begin
          acc <= acc + lane_sum;
          if (beat_left != '0) beat_left <= beat_left - BEAT_W'(1);
        end
        ST_WRITE: begin
          acc             <= '0;
          results_written <= results_written + CNT_W'(1);
          beat_left       <= BEAT_LAST;
          if (!last_pair) pair_idx <= pair_idx + PAIR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; an aborted run keeps earlier slots.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      a_mem[wr_pair][wr_idx] <= wr_a;
      b_mem[wr_pair][wr_idx] <= wr_b;
    end
    if (!rst && state == ST_WRITE) res_mem[pair_idx] <= acc;
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine with directed and random runs
// against a plain-arithmetic reference model.
module tb_dot_product_engine;

  localparam int DW    = 8;
  localparam int VL    = 8;
  localparam int LN    = 2;
  localparam int NP    = 4;
  localparam int BEATS = VL / LN;
  localparam int RW    = 2 * DW + $clog2(VL);
  localparam int CW    = $clog2(NP) + 1;
  localparam int LIMIT = 200;
  localparam int NONE  = -10;

  logic                  clk = 1'b0;
  logic                  rst, start, cfg_signed;
  logic [CW-1:0]         pair_count;
  logic                  busy, done, cfg_err;
  logic                  wr_en;
  logic [$clog2(NP)-1:0] wr_pair;
  logic [$clog2(VL)-1:0] wr_idx;
  logic [DW-1:0]         wr_a, wr_b;
  logic                  wr_err;
  logic                  rd_en;
  logic [$clog2(NP)-1:0] rd_addr;
  logic [RW-1:0]         rd_data;
  logic                  rd_valid;
  logic [CW-1:0]         results_written;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ma   [NP][VL];
  logic [DW-1:0] mb   [NP][VL];
  logic [RW-1:0] mres [NP];

  dot_product_engine #(
    .DATA_WIDTH(DW), .VEC_LEN(VL), .LANES(LN), .NUM_PAIRS(NP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pair_count(pair_count),
    .cfg_signed(cfg_signed), .busy(busy), .done(done), .cfg_err(cfg_err),
    .wr_en(wr_en), .wr_pair(wr_pair), .wr_idx(wr_idx), .wr_a(wr_a),
    .wr_b(wr_b), .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .results_written(results_written)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] ref_dot(input int p, input bit sgn);
    longint s = 0;
    for (int i = 0; i < VL; i++) begin
      if (sgn) s += longint'($signed(ma[p][i])) * longint'($signed(mb[p][i]));
      else     s += longint'(ma[p][i]) * longint'(mb[p][i]);
    end
    return s[RW-1:0];
  endfunction

  task automatic wr_op(input int p, input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    wr_en = 1'b1; wr_pair = p[$clog2(NP)-1:0]; wr_idx = i[$clog2(VL)-1:0];
    wr_a = a; wr_b = b;
    tick();
    wr_en = 1'b0;
    ma[p][i] = a;
    mb[p][i] = b;
  endtask

  task automatic rd_chk(input string tag, input int p);
    rd_en = 1'b1; rd_addr = p[$clog2(NP)-1:0];
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_data), 32'(mres[p]));
  endtask

  // One run; optional hooks: a result read in cycle snoop_cyc and a rejected
  // operand write in cycle wr_cyc (0 = same cycle as start).
  task automatic run(input int pc, input bit sgn, input int snoop_cyc, input int snoop_slot,
                     input int wr_cyc);
    int n;
    int busy_cnt = 0;
    logic [RW-1:0] snoop_exp = '0;
    start = 1'b1; pair_count = CW'(pc); cfg_signed = sgn;
    if (wr_cyc == 0) begin
      wr_en = 1'b1; wr_pair = NP - 1; wr_idx = VL - 1;
      wr_a = ~ma[NP-1][VL-1]; wr_b = ~mb[NP-1][VL-1];
    end
    tick();
    start = 1'b0;
    for (n = 1; n <= LIMIT; n++) begin
      if (n == snoop_cyc) begin
        rd_en = 1'b1; rd_addr = snoop_slot[$clog2(NP)-1:0]; snoop_exp = mres[snoop_slot];
      end
      if (n == snoop_cyc + 1) begin
        rd_en = 1'b0;
        chk("snoop_old_value", 32'(rd_data), 32'(snoop_exp));
      end
      if (n == wr_cyc && n > 0) begin
        wr_en = 1'b1; wr_pair = NP - 1; wr_idx = VL - 1;
        wr_a = ~ma[NP-1][VL-1]; wr_b = ~mb[NP-1][VL-1];
      end
      if (n == wr_cyc + 1) begin
        wr_en = 1'b0;
        chk("wr_err_pulse", 32'(wr_err), 32'd1);
      end
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cnt++;
      tick();
    end
    chk("done_cycle", n, pc * (BEATS + 1) + 1);
    chk("busy_cycles", busy_cnt, pc * (BEATS + 1));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("results_written", 32'(results_written), pc);
    for (int k = 0; k < pc; k++) mres[k] = ref_dot(k, sgn);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int bad_pc [2] = '{0, 5};
    rst = 1'b1; start = 1'b0; pair_count = '0; cfg_signed = 1'b0;
    wr_en = 1'b0; wr_pair = '0; wr_idx = '0; wr_a = '0; wr_b = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_results_written", 32'(results_written), 32'd0);
    rst = 1'b0;
    tick();

    // all four pairs at 0xFF unsigned
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < VL; i++) wr_op(p, i, 8'hFF, 8'hFF);
    run(4, 1'b0, NONE, 0, NONE);
    for (int p = 0; p < NP; p++) begin
      chk("ff_model", 32'(mres[p]), 32'h7F008);
      rd_chk("ff_slot", p);
    end

    // write coinciding with an accepted start is dropped
    run(1, 1'b0, NONE, 0, 0);

    // pair 0: A=1..8, B=1
    for (int i = 0; i < VL; i++) wr_op(0, i, 8'(i + 1), 8'd1);
    run(1, 1'b0, NONE, 0, NONE);
    rd_chk("pair0_36", 0);
    chk("pair0_const", 32'(mres[0]), 32'd36);

    // pair 1: A=0xFF, B=0x02
    for (int i = 0; i < VL; i++) wr_op(1, i, 8'hFF, 8'h02);
    run(2, 1'b1, NONE, 0, NONE);
    chk("pair1_signed_const", 32'(mres[1]), 32'h7FFF0);
    rd_chk("pair1_signed", 1);
    // unsigned rerun: read slot 1 while it is being rewritten, write while busy
    run(2, 1'b0, 2 * (BEATS + 1), 1, 3);
    chk("pair1_unsigned_const", 32'(mres[1]), 32'h00FF0);
    rd_chk("pair1_unsigned", 1);
    rd_chk("pair0_again", 0);
    // pair 3 must still be all 0xFF after the two rejected writes
    run(4, 1'b0, NONE, 0, NONE);
    for (int p = 0; p < NP; p++) rd_chk("after_rejects", p);
    chk("pair3_intact", 32'(mres[3]), 32'h7F008);

    // illegal starts
    foreach (bad_pc[k]) begin
      start = 1'b1; pair_count = CW'(bad_pc[k]);
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
      chk("cfg_err_busy", 32'(busy), 32'd0);
      tick();
      chk("cfg_err_clear", 32'(cfg_err), 32'd0);
      chk("cfg_err_no_done", 32'(done), 32'd0);
      chk("cfg_err_idle", 32'(busy), 32'd0);
    end

    // random operands and configurations
    for (int it = 0; it < 6; it++) begin
      int pc;
      bit sgn;
      for (int p = 0; p < NP; p++)
        for (int i = 0; i < VL; i++) wr_op(p, i, 8'($urandom), 8'($urandom));
      pc  = $urandom_range(1, NP);
      sgn = 1'($urandom);
      run(pc, sgn, NONE, 0, NONE);
      for (int p = 0; p < NP; p++) rd_chk("rand_slot", p);
    end

    // reset in cycle 8 of a 4-pair run
    for (int i = 0; i < VL; i++) wr_op(0, i, 8'(i + 3), 8'd5);
    for (int p = 1; p < NP; p++)
      for (int i = 0; i < VL; i++) wr_op(p, i, 8'h11, 8'h22);
    start = 1'b1; pair_count = CW'(4); cfg_signed = 1'b0;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("mid_rw_before_rst", 32'(results_written), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rw", 32'(results_written), 32'd0);
    mres[0] = ref_dot(0, 1'b0);
    chk("mid_slot0_const", 32'(mres[0]), 32'd260);
    begin
      int seen_done = 0;
      int seen_busy = 0;
      repeat (30) begin
        tick();
        if (done === 1'b1) seen_done++;
        if (busy === 1'b1) seen_busy++;
      end
      chk("mid_rst_stays_idle_done", seen_done, 0);
      chk("mid_rst_stays_idle_busy", seen_busy, 0);
    end
    for (int p = 0; p < NP; p++) rd_chk("mid_rst_slot", p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
